// File: rtl/apb_pkg.sv
// Shared APB definitions for the bridge, the slave RAM and its interface.
// Holds bus widths and the requester state encoding.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_mst_state_e;

endpackage

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB requester with a valid/ready command port,
// a valid/ready response port and an ACCESS-phase timeout.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  apb_mst_state_e state_q, state_d;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic              psel_q, psel_d;
  logic              pen_q, pen_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rerr_q, rerr_d;
  logic              rto_q, rto_d;

  logic accept;
  logic timed_out;

  assign cmd_ready = presetn && (state_q == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign timed_out = !pready && (cnt_q == CNT_LAST);

  assign psel        = psel_q;
  assign penable     = pen_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rvalid_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = rerr_q;
  assign rsp_timeout = rto_q;

  // State register.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: SETUP lasts one cycle, ACCESS ends on pready or timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready || timed_out) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output next-values; everything holds unless a phase changes it.
  always_comb begin
    cnt_d    = cnt_q;
    psel_d   = psel_q;
    pen_d    = pen_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rerr_d   = rerr_q;
    rto_d    = rto_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          paddr_d  = cmd_addr;
          pwrite_d = cmd_write;
          pwdata_d = cmd_wdata;
          psel_d   = 1'b1;
          pen_d    = 1'b0;
        end
      end
      SETUP: begin
        pen_d = 1'b1;
        cnt_d = '0;
      end
      ACCESS: begin
        if (pready) begin
          psel_d   = 1'b0;
          pen_d    = 1'b0;
          rvalid_d = 1'b1;
          rerr_d   = pslverr;
          rto_d    = 1'b0;
          if (!pwrite_q && !pslverr) begin
            rdata_d = prdata;
          end else begin
            rdata_d = '0;
          end
        end else if (timed_out) begin
          psel_d   = 1'b0;
          pen_d    = 1'b0;
          rvalid_d = 1'b1;
          rerr_d   = 1'b1;
          rto_d    = 1'b1;
          rdata_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rvalid_d = 1'b0;
        end
      end
      default: begin
        psel_d = 1'b0;
        pen_d  = 1'b0;
      end
    endcase
  end

  // Registered APB and response outputs.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt_q    <= '0;
      psel_q   <= 1'b0;
      pen_q    <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rerr_q   <= 1'b0;
      rto_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      psel_q   <= psel_d;
      pen_q    <= pen_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rerr_q   <= rerr_d;
      rto_q    <= rto_d;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: 32-word APB RAM slave with configurable
// wait states, table vectors, random traffic and reset/backpressure cases.
module tb_apb_master_bridge;

  localparam int TO = 16;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_timeout;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr;

  int checks = 0;
  int errors = 0;

  apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  // ---------------- APB RAM slave model ----------------
  logic [31:0] mem [32];
  int          wait_ws = 0;
  bit          stall = 0;
  bit          junk = 0;
  int          acc;
  logic        in_acc, in_rng;

  assign in_acc  = psel && penable;
  assign in_rng  = (paddr < 32);
  assign pready  = in_acc ? (!stall && acc >= wait_ws) : junk;
  assign pslverr = in_acc ? (pready && !in_rng) : junk;
  assign prdata  = in_rng ? mem[paddr[4:0]] : 32'hBAD0_BAD0;

  always @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      acc <= 0;
    end else begin
      if (in_acc && !pready) acc <= acc + 1;
      else acc <= 0;
      if (in_acc && pready && pwrite && in_rng)
        mem[paddr[4:0]] <= pwdata;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Protocol monitor: stability while selected, single SETUP cycle.
  logic        p_psel = 0, p_pen = 0, p_pwr = 0;
  logic [31:0] p_addr = 0, p_wd = 0;
  always @(negedge pclk) begin
    if (!presetn) begin
      p_psel = 0;
      p_pen  = 0;
    end else begin
      if (psel || penable) begin
        chk("pen_implies_psel", {31'b0, !penable || psel}, 32'd1);
        chk("no_cmd_ready_while_sel", {31'b0, cmd_ready}, 32'd0);
      end
      if (psel && p_psel) begin
        chk("paddr_stable", paddr, p_addr);
        chk("pwdata_stable", pwdata, p_wd);
        chk("pwrite_stable", {31'b0, pwrite}, {31'b0, p_pwr});
        chk("one_setup_cycle",
            {31'b0, p_pen || penable}, 32'd1);
      end
      if (penable && !p_pen)
        chk("pen_after_setup", {31'b0, p_psel && !p_pen}, 32'd1);
      p_psel = psel;
      p_pen  = penable;
      p_pwr  = pwrite;
      p_addr = paddr;
      p_wd   = pwdata;
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] rd;
    bit          er;
    bit          to;
    int          lat;
  } exp_t;

  logic [31:0] ref_mem [32];

  // Response expected from a 32-word RAM given wait states / stall.
  function automatic exp_t ref_txn(input bit w, input logic [31:0] a,
                                   input logic [31:0] d, input int wt,
                                   input bit st);
    exp_t e;
    bit ok;
    if (st || wt >= TO) begin
      e.rd = 0; e.er = 1; e.to = 1; e.lat = TO + 1;
    end else begin
      ok    = (a < 32);
      e.er  = !ok;
      e.to  = 0;
      e.lat = 2 + wt;
      e.rd  = (!w && ok) ? ref_mem[a[4:0]] : 32'h0;
      if (w && ok) ref_mem[a[4:0]] = d;
    end
    return e;
  endfunction

  // ---------------- driver ----------------
  // Called and returns at a negedge. lat = edges from accept to rsp_valid.
  task automatic run_txn(input bit w, input logic [31:0] a,
                         input logic [31:0] d, input int wt,
                         input bit st, input int hold,
                         output logic [31:0] rd, output bit er,
                         output bit to, output int lat);
    int n;
    int cnt;
    wait_ws = wt;
    stall   = st;
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge pclk); n++; end
    chk("cmd_ready_wait", {31'b0, n < 20}, 32'd1);
    cnt = 0;
    do begin
      @(negedge pclk);
      cnt++;
      if (cnt == 1) begin
        cmd_valid = 0;
        chk("setup_psel", {31'b0, psel}, 32'd1);
        chk("setup_pen", {31'b0, penable}, 32'd0);
      end
    end while (!rsp_valid && cnt < 64);
    lat = cnt - 1;
    rd = rsp_rdata; er = rsp_err; to = rsp_timeout;
    chk("rsp_psel_low", {30'b0, psel, penable}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge pclk);
      chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
      chk("hold_rdata", rsp_rdata, rd);
      chk("hold_flags", {30'b0, rsp_err, rsp_timeout},
          {30'b0, er, to});
      chk("hold_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    end
    rsp_ready = 1;
    @(negedge pclk);
    rsp_ready = 0;
    chk("post_hs_valid", {31'b0, rsp_valid}, 32'd0);
    chk("post_hs_ready", {31'b0, cmd_ready}, 32'd1);
    chk("paddr_kept", paddr, a);
    chk("pwdata_kept", pwdata, d);
    chk("pwrite_kept", {31'b0, pwrite}, {31'b0, w});
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    int          wt;
    bit          st;
    logic [31:0] rd;
    bit          er;
    bit          to;
    int          lat;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  initial begin
    logic [31:0] rd, rd2;
    bit          er, to;
    int          lat, n;
    exp_t        e, e2;

    vecs[0]  = '{1'b1, 32'h4,  32'hDEADBEEF, 1, 1'b0, 32'h0, 1'b0, 1'b0, 3};
    vecs[1]  = '{1'b0, 32'h4,  32'h0, 1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 3};
    vecs[2]  = '{1'b0, 32'h40, 32'h0, 1, 1'b0, 32'h0, 1'b1, 1'b0, 3};
    vecs[3]  = '{1'b0, 32'h8,  32'h0, 0, 1'b1, 32'h0, 1'b1, 1'b1, 17};
    vecs[4]  = '{1'b1, 32'h0,  32'h12345678, 0, 1'b0, 32'h0, 1'b0, 1'b0, 2};
    vecs[5]  = '{1'b0, 32'h0,  32'h0, 0, 1'b0, 32'h12345678, 1'b0, 1'b0, 2};
    vecs[6]  = '{1'b1, 32'h1F, 32'hA5A5A5A5, 3, 1'b0, 32'h0, 1'b0, 1'b0, 5};
    vecs[7]  = '{1'b0, 32'h1F, 32'h0, 3, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0, 5};
    vecs[8]  = '{1'b1, 32'h20, 32'h55, 0, 1'b0, 32'h0, 1'b1, 1'b0, 2};
    vecs[9]  = '{1'b0, 32'h1F, 32'h0, 15, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0, 17};
    vecs[10] = '{1'b1, 32'h4,  32'h11111111, 16, 1'b0, 32'h0, 1'b1, 1'b1, 17};
    vecs[11] = '{1'b0, 32'h4,  32'h0, 2, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 4};

    for (int i = 0; i < 32; i++) begin
      mem[i] = 0;
      ref_mem[i] = 0;
    end
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
    rsp_ready = 0;
    presetn = 0;

    // Reset state
    #12;
    chk("rst_psel", {30'b0, psel, penable}, 32'd0);
    chk("rst_pwrite", {31'b0, pwrite}, 32'd0);
    chk("rst_paddr", paddr, 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    chk("rst_rsp", {29'b0, rsp_valid, rsp_err, rsp_timeout}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    @(negedge pclk);
    presetn = 1;
    @(negedge pclk);
    chk("idle_cmd_ready", {31'b0, cmd_ready}, 32'd1);

    // Reset in the 2nd ACCESS cycle
    wait_ws = 5; stall = 0;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h3; cmd_wdata = 0;
    @(negedge pclk);
    cmd_valid = 0;
    @(negedge pclk);
    @(negedge pclk);
    chk("pre_rst_sel", {30'b0, psel, penable}, 32'd3);
    #1 presetn = 0;
    #1;
    chk("mid_rst_sel", {30'b0, psel, penable}, 32'd0);
    chk("mid_rst_rsp", {31'b0, rsp_valid}, 32'd0);
    @(negedge pclk);
    presetn = 1;
    @(negedge pclk);
    chk("post_rst_ready", {31'b0, cmd_ready}, 32'd1);
    e = ref_txn(0, 32'h0, 32'h0, 0, 0);
    run_txn(0, 32'h0, 32'h0, 0, 0, 0, rd, er, to, lat);
    chk("post_rst_rdata", rd, e.rd);
    chk("post_rst_err", {31'b0, er}, {31'b0, e.er});

    // Table vectors
    for (int i = 0; i < NV; i++) begin
      e = ref_txn(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].wt, vecs[i].st);
      run_txn(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].wt, vecs[i].st,
              i % 3, rd, er, to, lat);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].rd);
      chk($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, vecs[i].er});
      chk($sformatf("vec%0d_to", i), {31'b0, to}, {31'b0, vecs[i].to});
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
    end
    chk("ram_word4", mem[4], 32'hDEADBEEF);
    chk("ram_word0", mem[0], 32'h12345678);

    // Response backpressure with a second command waiting
    wait_ws = 1; stall = 0;
    e = ref_txn(0, 32'h1F, 32'h0, 1, 0);
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h1F; cmd_wdata = 0;
    @(negedge pclk);
    cmd_write = 1; cmd_addr = 32'h9; cmd_wdata = 32'h99;
    n = 0;
    while (!rsp_valid && n < 40) begin @(negedge pclk); n++; end
    chk("bp_rsp_seen", {31'b0, rsp_valid}, 32'd1);
    rd = rsp_rdata;
    chk("bp_rdata", rd, e.rd);
    for (int i = 0; i < 5; i++) begin
      @(negedge pclk);
      chk("bp_hold_rdata", rsp_rdata, rd);
      chk("bp_hold_valid", {31'b0, rsp_valid}, 32'd1);
      chk("bp_no_ready", {31'b0, cmd_ready}, 32'd0);
      chk("bp_no_psel", {31'b0, psel}, 32'd0);
    end
    rsp_ready = 1;
    @(negedge pclk);
    rsp_ready = 0;
    chk("bp_ready_next", {31'b0, cmd_ready}, 32'd1);
    @(negedge pclk);
    cmd_valid = 0;
    chk("bp_second_psel", {31'b0, psel}, 32'd1);
    chk("bp_second_addr", paddr, 32'h9);
    e2 = ref_txn(1, 32'h9, 32'h99, 1, 0);
    n = 0;
    while (!rsp_valid && n < 40) begin @(negedge pclk); n++; end
    chk("bp_second_err", {30'b0, rsp_err, rsp_timeout},
        {30'b0, e2.er, e2.to});
    rsp_ready = 1;
    @(negedge pclk);
    rsp_ready = 0;
    chk("ram_word9", mem[9], 32'h99);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      bit          w, st;
      logic [31:0] a, d;
      int          wt, hold;
      w    = $urandom_range(0, 1) == 1;
      a    = $urandom_range(0, 39);
      d    = $urandom;
      st   = $urandom_range(0, 9) == 0;
      wt   = ($urandom_range(0, 5) == 0) ? $urandom_range(14, 17)
                                         : $urandom_range(0, 3);
      hold = $urandom_range(0, 3);
      junk = $urandom_range(0, 1) == 1;
      e = ref_txn(w, a, d, wt, st);
      run_txn(w, a, d, wt, st, hold, rd2, er, to, lat);
      chk($sformatf("rnd%0d_rdata", i), rd2, e.rd);
      chk($sformatf("rnd%0d_flags", i), {30'b0, er, to},
          {30'b0, e.er, e.to});
      chk($sformatf("rnd%0d_lat", i), lat, e.lat);
    end
    junk = 0;
    for (int i = 0; i < 32; i++)
      chk($sformatf("ram_final%0d", i), mem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
